move_sequencer: RTL and testbench

//  Queues cube-face move codes and issues them one at a time to the stepper move engine
//  (move_to_step) via its next_move/move_start/move_done handshake.

---
 rtl/move_sequencer.sv | 126 ++++++++++++
 tb/tb_move_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// move_sequencer: queues move codes and issues them one at a time to the stepper with a settle gap.
// Define MOVE_SEQ_TIMEOUT_EN to add a WAIT_DONE watchdog that latches fault and parks in FAULT.
module move_sequencer #(
  parameter int MOVE_W        = 5,
  parameter int DEPTH_LOG2    = 6,
  parameter int SETTLE_CYCLES = 250000
`ifdef MOVE_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000000
`endif
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                push,
  input  logic [MOVE_W-1:0]   push_move,
  input  logic                run,
  input  logic                flush,
  input  logic                move_done,
  output logic [MOVE_W-1:0]   next_move,
  output logic                move_start,
  output logic                busy,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                overflow,
  output logic                fault
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int SW    = $clog2(SETTLE_CYCLES + 1);

`ifdef MOVE_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, SETTLE, FAULT} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, SETTLE} state_t;
`endif

  state_t                state_q, state_d;
  logic [MOVE_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [MOVE_W-1:0]     nm_q, nm_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic                  ovf_q, ovf_d, start_q, done_q;
  logic                  do_deq, do_push, can_issue, done_edge;

  assign full      = count_q == CW'(DEPTH);
  assign do_deq    = state_q == ISSUE;
  // a full queue still accepts a push when the same cycle dequeues
  assign do_push   = push && !flush && (!full || do_deq);
  assign can_issue = run && count_q != '0 && !flush;
  assign done_edge = move_done && !done_q;
  assign rd_d      = flush ? wr_q : do_deq ? rd_q + DEPTH_LOG2'(1) : rd_q;
  assign wr_d      = do_push ? wr_q + DEPTH_LOG2'(1) : wr_q;
  assign count_d   = flush ? '0 : count_q + CW'(do_push) - CW'(do_deq);
  assign ovf_d     = !flush && (ovf_q || (push && full && !do_deq));
  assign nm_d      = do_deq ? mem[rd_q] : nm_q;

  assign next_move  = nm_q;
  assign move_start = start_q;
  assign busy       = state_q == ISSUE || state_q == WAIT_DONE || state_q == SETTLE;
  assign count      = count_q;
  assign overflow   = ovf_q;

`ifdef MOVE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q;
  logic          wd_expired;
  assign wd_expired = wd_q == TW'(TIMEOUT_CYCLES - 1);
  assign fault      = state_q == FAULT;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) wd_q <= '0;
    else          wd_q <= state_q == WAIT_DONE ? wd_q + TW'(1) : '0;
`else
  logic wd_expired;
  assign wd_expired = 1'b0;
  assign fault      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      IDLE:      state_d = can_issue ? ISSUE : IDLE;
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done_edge) begin
          state_d  = SETTLE;
          settle_d = SW'(SETTLE_CYCLES - 1);
        end
`ifdef MOVE_SEQ_TIMEOUT_EN
        else if (wd_expired) state_d = FAULT;
`endif
      end
      SETTLE: begin
        if (settle_q == '0) state_d = can_issue ? ISSUE : IDLE;
        else settle_d = settle_q - SW'(1);
      end
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge clock)
    if (do_push) mem[wr_q] <= push_move;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      nm_q     <= '0;
      settle_q <= '0;
      ovf_q    <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      count_q  <= count_d;
      nm_q     <= nm_d;
      settle_q <= settle_d;
      ovf_q    <= ovf_d;
      start_q  <= do_deq;
      done_q   <= move_done;
    end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed vector table plus hand sequences for issue latency, spacing,
// flush, asynchronous reset and the optional watchdog.
module tb_move_sequencer;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       push = 1'b0, run = 1'b0, flush = 1'b0, move_done = 1'b0;
  logic [4:0] push_move = '0;
  logic [4:0] next_move;
  logic       move_start, busy, full, overflow, fault;
  logic [2:0] count;
  int         n_vec = 0, n_err = 0;

  always #5 clock = ~clock;

  move_sequencer #(
    .MOVE_W(5), .DEPTH_LOG2(2), .SETTLE_CYCLES(4)
`ifdef MOVE_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .clock(clock), .reset_n(reset_n), .push(push), .push_move(push_move), .run(run),
    .flush(flush), .move_done(move_done), .next_move(next_move), .move_start(move_start),
    .busy(busy), .count(count), .full(full), .overflow(overflow), .fault(fault)
  );

  typedef struct {
    logic       push;
    logic [4:0] mv;
    logic       run, flush, done;
    int         cnt;
    logic       full, ovf, busy, start;
    logic [4:0] nm;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // stepper model: latches move_start on the next edge, raises move_done 10 cycles later
  task automatic serve(input logic [4:0] mv, output int waited);
    waited = 0;
    while (!move_start && waited < 100) begin
      step();
      waited++;
    end
    chk("serve_start_seen", move_start, 1);
    chk("serve_next_move", next_move, mv);
    repeat (11) step();
    move_done = 1'b1;
    step();
    move_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!move_start && n < 100) begin
      step();
      n++;
    end
    chk("start_seen", move_start, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, starts;
    //           push mv    run flush done cnt full ovf busy start nm
    tbl[0]  = '{1, 5'h01, 0, 0, 0, 1, 0, 0, 0, 0, 5'h05};
    tbl[1]  = '{1, 5'h02, 0, 0, 0, 2, 0, 0, 0, 0, 5'h05};
    tbl[2]  = '{1, 5'h03, 0, 0, 0, 3, 0, 0, 0, 0, 5'h05};
    tbl[3]  = '{1, 5'h04, 0, 0, 0, 4, 1, 0, 0, 0, 5'h05};
    tbl[4]  = '{1, 5'h05, 0, 0, 0, 4, 1, 1, 0, 0, 5'h05};
    tbl[5]  = '{0, 5'h00, 0, 0, 0, 4, 1, 1, 0, 0, 5'h05};
    tbl[6]  = '{0, 5'h00, 1, 0, 0, 4, 1, 1, 1, 0, 5'h05};
    tbl[7]  = '{1, 5'h06, 1, 0, 0, 4, 1, 1, 1, 1, 5'h01};
    tbl[8]  = '{0, 5'h00, 1, 0, 0, 4, 1, 1, 1, 0, 5'h01};
    tbl[9]  = '{0, 5'h00, 1, 0, 1, 4, 1, 1, 1, 0, 5'h01};
    tbl[10] = '{0, 5'h00, 0, 0, 0, 4, 1, 1, 1, 0, 5'h01};
    tbl[11] = '{0, 5'h00, 0, 0, 0, 4, 1, 1, 1, 0, 5'h01};
    tbl[12] = '{0, 5'h00, 0, 0, 0, 4, 1, 1, 1, 0, 5'h01};
    tbl[13] = '{0, 5'h00, 0, 0, 0, 4, 1, 1, 0, 0, 5'h01};
    tbl[14] = '{0, 5'h00, 0, 0, 0, 4, 1, 1, 0, 0, 5'h01};

    step();
    step();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", move_start, 0);
    chk("rst_next_move", next_move, 0);
    chk("rst_flags", {full, overflow, fault}, 0);
    reset_n = 1'b1;
    step();

    // single move: start three cycles after push, four settle cycles after the done edge
    run = 1'b1;
    push = 1'b1;
    push_move = 5'h03;
    step();
    push = 1'b0;
    chk("t1_count_after_push", count, 1);
    step();
    chk("t1_start_early", move_start, 0);
    chk("t1_busy_issue", busy, 1);
    step();
    chk("t1_start", move_start, 1);
    chk("t1_next_move", next_move, 5'h03);
    chk("t1_count_dequeued", count, 0);
    step();
    chk("t1_start_one_cycle", move_start, 0);
    step();
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_busy_settle%0d", i), busy, 1);
      step();
    end
    chk("t1_busy_done", busy, 0);
    chk("t1_count_done", count, 0);
    chk("t1_next_move_held", next_move, 5'h03);

    // three moves in order with start-to-start spacing of 10+1+4+2 cycles
    push = 1'b1;
    push_move = 5'h01;
    step();
    push_move = 5'h02;
    step();
    push_move = 5'h05;
    step();
    push = 1'b0;
    serve(5'h01, w);
    serve(5'h02, w);
    chk("t2_gap_1_2", 12 + w, 17);
    serve(5'h05, w);
    chk("t2_gap_2_3", 12 + w, 17);
    wait_idle();
    chk("t2_count_empty", count, 0);

    // fill/overflow/push-with-dequeue and a paused settle
    for (int i = 0; i < 15; i++) begin
      push = tbl[i].push;
      push_move = tbl[i].mv;
      run = tbl[i].run;
      flush = tbl[i].flush;
      move_done = tbl[i].done;
      step();
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d_full", i), full, tbl[i].full);
      chk($sformatf("v%0d_overflow", i), overflow, tbl[i].ovf);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d_start", i), move_start, tbl[i].start);
      chk($sformatf("v%0d_next_move", i), next_move, tbl[i].nm);
    end
    push = 1'b0;
    flush = 1'b0;
    move_done = 1'b0;
    run = 1'b1;
    serve(5'h02, w);
    serve(5'h03, w);
    serve(5'h04, w);
    serve(5'h06, w);
    wait_idle();
    chk("t3_drained", count, 0);
    chk("t3_overflow_sticky", overflow, 1);

    // flush while waiting for done: current move finishes, nothing else issues
    push = 1'b1;
    push_move = 5'h07;
    step();
    push_move = 5'h08;
    step();
    push_move = 5'h09;
    step();
    push = 1'b0;
    wait_start();
    chk("t4_next_move", next_move, 5'h07);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_count_flushed", count, 0);
    chk("t4_overflow_cleared", overflow, 0);
    chk("t4_busy_during", busy, 1);
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (move_start) starts++;
    end
    chk("t4_no_more_starts", starts, 0);
    chk("t4_idle", busy, 0);

    // asynchronous reset in the middle of the settle gap
    push = 1'b1;
    push_move = 5'h0A;
    step();
    push_move = 5'h0B;
    step();
    push = 1'b0;
    wait_start();
    step();
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    step();
    chk("t5_in_settle", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_next_move", next_move, 0);
    chk("t5_rst_start", move_start, 0);
    step();
    reset_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (move_start) starts++;
    end
    chk("t5_queue_empty_no_start", starts, 0);
    chk("t5_count_after", count, 0);

    // stepper never answers
    push = 1'b1;
    push_move = 5'h0C;
    step();
    push = 1'b0;
    wait_start();
`ifdef MOVE_SEQ_TIMEOUT_EN
    repeat (19) step();
    chk("t6_fault_not_yet", fault, 0);
    chk("t6_busy_waiting", busy, 1);
    step();
    chk("t6_fault_set", fault, 1);
    chk("t6_busy_fault", busy, 0);
    push = 1'b1;
    push_move = 5'h0D;
    step();
    push = 1'b0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (move_start) starts++;
    end
    chk("t6_no_start_in_fault", starts, 0);
    chk("t6_queue_kept", count, 1);
    chk("t6_fault_sticky", fault, 1);
`else
    repeat (25) step();
    chk("t6_fault_tied", fault, 0);
    chk("t6_still_waiting", busy, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
